// File: rtl/regfile_dump.sv
// regfile_dump: walks the regfile read port and streams every register out as an addressed valid/ready beat
// Ports: clk/reset_n   clock and asynchronous active-low reset
//        start         request a dump, sampled only while idle
//        ra/rd         regfile read address and its combinational read data
//        out_valid/out_ready/out_data/out_addr  beat stream, one register per beat
//        busy          high whenever a dump is in progress
//        done          one-cycle pulse after the final handshake
// Optional: define REGFILE_DUMP_CHECKSUM_EN to add checksum, the XOR of all accepted beats of the current dump.
module regfile_dump #(
    parameter int W        = 64,
    parameter int LAST_REG = 31
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic [4:0]   ra,
    input  logic [W-1:0] rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [4:0]   out_addr,
    output logic         busy,
    output logic         done
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    output logic [W-1:0] checksum
`endif
);
    typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
    localparam logic [4:0] LAST = 5'(LAST_REG);
    state_t state, nxt;
    logic [4:0] idx;
    logic hs;
    assign hs = state == SEND && out_ready;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? READ : IDLE;
            READ:    nxt = SEND;
            SEND:    nxt = hs ? (idx == LAST ? FIN : READ) : SEND;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            ra        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    idx      <= '0;
                    ra       <= '0;
                    busy     <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    checksum <= '0;
`endif
                end
                // ra was registered last cycle, so rd has settled by this edge
                READ: begin
                    out_data  <= rd;
                    out_addr  <= idx;
                    out_valid <= 1'b1;
                end
                SEND: if (hs) begin
                    out_valid <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    checksum  <= checksum ^ out_data;
`endif
                    if (idx == LAST) done <= 1'b1;
                    else begin
                        idx <= idx + 5'd1;
                        ra  <= idx + 5'd1;
                    end
                end
                // park the read address back at 0 for idle
                FIN: begin
                    busy <= 1'b0;
                    ra   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump (default 32-register instance plus a LAST_REG=3 instance)
`timescale 1ns/1ps
module tb_regfile_dump;
    localparam int W = 64;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [4:0] ra, out_addr;
    logic [W-1:0] rd, out_data;
    logic out_valid, busy, done;
    logic start3 = 1'b0, ready3 = 1'b0;
    logic [4:0] ra3, out_addr3;
    logic [W-1:0] rd3, out_data3;
    logic out_valid3, busy3, done3;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [W-1:0] checksum, checksum3;
`endif
    logic [W-1:0] regs [32];
    int checks = 0, errors = 0, done_cnt = 0, done3_cnt = 0, ra3_max = 0;

    assign rd  = regs[ra];
    assign rd3 = regs[ra3];

    regfile_dump #(.W(W), .LAST_REG(31)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    regfile_dump #(.W(W), .LAST_REG(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .ra(ra3), .rd(rd3),
        .out_valid(out_valid3), .out_ready(ready3), .out_data(out_data3),
        .out_addr(out_addr3), .busy(busy3), .done(done3)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        , .checksum(checksum3)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (done3 === 1'b1) done3_cnt++;
        if (int'(ra3) > ra3_max) ra3_max = int'(ra3);
    end

    function automatic logic [W-1:0] exp_data(input int i);
        return (i == 31) ? '0 : W'(i);
    endfunction

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (out_valid !== 1'b1 && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        ok = out_valid === 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ra, out_valid, out_data, out_addr, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: ra=%0d valid=%b data=%h addr=%0d busy=%b done=%b, required all 0",
                     ra, out_valid, out_data, out_addr, busy, done);
        end
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_dump();
        int d0 = done_cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_read: busy=%b valid=%b, required busy=1 valid=0", busy, out_valid);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 5'(i) || out_data !== exp_data(i)) begin
                errors++;
                $display("FAIL full_beat %0d: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                         i, out_valid, out_addr, out_data, i, exp_data(i));
            end
            @(posedge clk); #1;
            if (i < 31) begin
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || ra !== 5'(i + 1)) begin
                    errors++;
                    $display("FAIL full_gap %0d: valid=%b busy=%b done=%b ra=%0d, required 0 1 0 %0d",
                             i, out_valid, busy, done, ra, i + 1);
                end
                @(posedge clk); #1;
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b busy=%b valid=%b, required 1 1 0", done, busy, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ra !== 5'd0) begin
            errors++;
            $display("FAIL full_idle: done=%b busy=%b ra=%0d, required 0 0 0", done, busy, ra);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL full_done_count: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok || out_addr !== 5'(i) || out_data !== exp_data(i)) begin
                errors++;
                $display("FAIL bp_beat %0d: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                         i, out_valid, out_addr, out_data, i, exp_data(i));
            end
            if (i == 5) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_addr !== 5'd5 || out_data !== 64'd5) begin
                        errors++;
                        $display("FAIL bp_hold: valid=%b addr=%0d data=%h, required 1 5 5", out_valid, out_addr, out_data);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: done=%b, required 1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int d0 = done_cnt;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok || out_addr !== 5'(i) || out_data !== exp_data(i)) begin
                errors++;
                $display("FAIL ign_beat %0d: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                         i, out_valid, out_addr, out_data, i, exp_data(i));
            end
            if (i == 12) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ign_end: busy=%b valid=%b done_pulses=%0d, required 0 0 1", busy, out_valid, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            wait_valid(ok);
            if (i < 10) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!ok || out_addr !== 5'd10 || ra !== 5'd10) begin
            errors++;
            $display("FAIL rst_mid_pre: valid=%b addr=%0d ra=%0d, required 1 10 10", out_valid, out_addr, ra);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ra !== 5'd0 || out_addr !== 5'd0 || out_data !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: valid=%b busy=%b ra=%0d addr=%0d data=%h done=%b, required all 0",
                     out_valid, busy, ra, out_addr, out_data, done);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || out_addr !== 5'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_restart: valid=%b addr=%0d data=%h, required 1 0 0", out_valid, out_addr, out_data);
        end
        while (busy === 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain: busy=%b after %0d cycles, required 0", busy, t);
        end
    endtask

    task automatic test_last_reg3();
        int d0 = done3_cnt;
        int t;
        ready3 = 1'b1;
        ra3_max = 0;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (out_valid3 !== 1'b1 && t < 8) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (out_valid3 !== 1'b1 || out_addr3 !== 5'(i) || out_data3 !== W'(i)) begin
                errors++;
                $display("FAIL lr3_beat %0d: valid=%b addr=%0d data=%h, required 1 %0d %0d",
                         i, out_valid3, out_addr3, out_data3, i, i);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done3 !== 1'b1 || busy3 !== 1'b1) begin
            errors++;
            $display("FAIL lr3_done: done=%b busy=%b, required 1 1", done3, busy3);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy3 !== 1'b0 || out_valid3 !== 1'b0 || done3_cnt - d0 != 1 || ra3_max > 3) begin
            errors++;
            $display("FAIL lr3_end: busy=%b valid=%b done_pulses=%0d ra_max=%0d, required 0 0 1 <=3",
                     busy3, out_valid3, done3_cnt - d0, ra3_max);
        end
        ready3 = 1'b0;
    endtask

`ifdef REGFILE_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int t = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (checksum !== '0) begin
            errors++;
            $display("FAIL cs_clear: checksum=%h, required 0", checksum);
        end
        while (done !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (done !== 1'b1 || checksum !== 64'h1F) begin
            errors++;
            $display("FAIL cs_first: done=%b checksum=%h, required 1 1f", done, checksum);
        end
        regs[0] = 64'hFF;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (done !== 1'b1 || checksum !== 64'hE0) begin
            errors++;
            $display("FAIL cs_second: done=%b checksum=%h, required 1 e0", done, checksum);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (checksum !== 64'hE0) begin
            errors++;
            $display("FAIL cs_hold: checksum=%h, required e0", checksum);
        end
        regs[0] = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 31) ? '0 : W'(i);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_last_reg3();
`ifdef REGFILE_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
